uart_mmio_slave: RTL

//  Memory-mapped 8N1 UART peripheral that sits directly downstream of the single-cycle core's data bus.

---
 rtl/uart_mmio_slave.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_slave.sv
// -----------------------------------------------------------------------------
// uart_mmio_slave
//
// Memory-mapped 8N1 UART placed directly on the single-cycle core's data bus.
// Loads see combinational read data in the same cycle. Register side effects
// (TX start, RX flag clear) take effect on the clock edge that ends the access.
//
// Register window: 16 bytes at BASE_ADDR, decoded on HADDR[LENGTH-1:4].
//   0x0 TXDATA  W: start a frame with HWDATA[7:0] when idle (dropped if busy)
//   0x4 RXDATA  R: {0, rx_data}; the read clears rx_valid/rx_overrun/frame_err
//   0x8 STATUS  R: {0, frame_err, rx_overrun, rx_valid, tx_busy}
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-low
//   HADDR     in   byte address from the core
//   HWDATA    in   store data, only [7:0] used
//   MemWrite  in   store strobe
//   MemRead   in   load strobe
//   uart_sel  out  HADDR falls inside the register window
//   HRDATA_o  out  combinational read data, 0 outside the window
//   tx        out  serial output, idles high
//   rx        in   serial input, asynchronous to clock
//   irq       out  receive interrupt
//
// Optional feature macro: UART_IRQ_EN
//   defined   -> irq is a registered copy of (rx_valid | rx_overrun)
//   undefined -> irq is tied low
// -----------------------------------------------------------------------------
module uart_mmio_slave #(
   parameter int unsigned       LENGTH    = 32,
   parameter logic [LENGTH-1:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned       BAUD_DIV  = 434
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [LENGTH-1:0] HADDR,
   input  logic [LENGTH-1:0] HWDATA,
   input  logic              MemWrite,
   input  logic              MemRead,
   output logic              uart_sel,
   output logic [LENGTH-1:0] HRDATA_o,
   output logic              tx,
   input  logic              rx,
   output logic              irq
);

   localparam int unsigned   CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [3:0]    OFF_TX   = 4'h0;
   localparam logic [3:0]    OFF_RX   = 4'h4;
   localparam logic [3:0]    OFF_ST   = 4'h8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Bus decode
   logic [3:0] offset;
   logic       wr_tx;
   logic       rd_clr;
   logic       unused_hwdata;

   assign uart_sel      = (HADDR[LENGTH-1:4] == BASE_ADDR[LENGTH-1:4]);
   assign offset        = HADDR[3:0];
   assign wr_tx         = MemWrite & uart_sel & (offset == OFF_TX);
   assign rd_clr        = MemRead & uart_sel & (offset == OFF_RX);
   assign unused_hwdata = ^HWDATA[LENGTH-1:8];

   // Transmitter state
   uart_state_e tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_q, tx_d;
   logic          tx_busy;
   logic          tx_last;

   // Receiver state
   logic          rx_meta_q, rx_meta_d;
   logic          rx_sync_q, rx_sync_d;
   logic          rx_prev_q, rx_prev_d;
   logic          rx_fall;
   uart_state_e rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_overrun_q, rx_overrun_d;
   logic          frame_err_q, frame_err_d;
   logic          rx_done;

   assign tx_busy   = (tx_state_q != ST_IDLE);
   assign tx_last   = (tx_cnt_q == CNT_LAST);
   assign tx        = tx_q;

   // Two-flop synchronizer plus one history flop for edge detection.
   assign rx_meta_d = rx;
   assign rx_sync_d = rx_meta_q;
   assign rx_prev_d = rx_sync_q;
   assign rx_fall   = rx_prev_q & ~rx_sync_q;
   assign rx_done   = (rx_state_q == ST_STOP) && (rx_cnt_q == CNT_LAST);

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_state_q   <= ST_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_q         <= 1'b1;
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= ST_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         tx_q         <= tx_d;
         rx_meta_q    <= rx_meta_d;
         rx_sync_q    <= rx_sync_d;
         rx_prev_q    <= rx_prev_d;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // TX next state: every non-idle state lasts exactly BAUD_DIV cycles.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      if (tx_state_q != ST_IDLE) begin
         tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
      end
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (wr_tx) begin
               tx_state_d = ST_START;
               tx_shift_d = HWDATA[7:0];
            end
         end
         ST_START: begin
            if (tx_last) begin
               tx_state_d = ST_DATA;
               tx_bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (tx_last) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = ST_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tx_last) begin
               tx_state_d = ST_IDLE;
            end
         end
         default: begin
            tx_state_d = ST_IDLE;
            tx_cnt_d   = '0;
         end
      endcase
   end

   // TX output: the line level is registered from the upcoming state so tx
   // is glitch-free and changes on the same edge as the state.
   always_comb begin
      tx_d = 1'b1;
      case (tx_state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = tx_shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // RX next state. START waits half a bit so that DATA/STOP sample mid-bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (rx_fall) begin
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               // A line already back high was only a glitch.
               rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = ST_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_IDLE;
            end
         end
         default: begin
            rx_state_d = ST_IDLE;
            rx_cnt_d   = '0;
         end
      endcase
   end

   // RX outputs. A completing byte overrides a same-edge RXDATA read, and
   // then only the new byte's condition drives the flags.
   always_comb begin
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q & ~rd_clr;
      rx_overrun_d = rx_overrun_q & ~rd_clr;
      frame_err_d  = frame_err_q & ~rd_clr;
      if (rx_done) begin
         rx_data_d    = rx_shift_q;
         rx_valid_d   = 1'b1;
         rx_overrun_d = rx_overrun_d | (rx_valid_q & ~rd_clr);
         frame_err_d  = frame_err_d | ~rx_sync_q;
      end
   end

   // Read mux
   always_comb begin
      HRDATA_o = '0;
      if (uart_sel) begin
         case (offset)
            OFF_RX:  HRDATA_o = {{(LENGTH-8){1'b0}}, rx_data_q};
            OFF_ST:  HRDATA_o = {{(LENGTH-4){1'b0}}, frame_err_q, rx_overrun_q,
                                 rx_valid_q, tx_busy};
            default: HRDATA_o = '0;
         endcase
      end
   end

`ifdef UART_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = rx_valid_q | rx_overrun_q;
   assign irq   = irq_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end
`else
   assign irq = 1'b0;
`endif

endmodule
